timerio: RTL and testbench
==========================

Name: timerio

Overview:
- 16-bit programmable down-counting interval timer peripheral on the CPU bus, decoded in the DS4 window ($E680, AD[4:3]==2'b00).
- Runs on sys_clk.
- Its `irq` output is ORed into the CPU IRQ alongside the simpleio and uartio interrupts.
- Provides periodic or one-shot tick interrupts for the monitor and OS.

Parameters:
- ID_VALUE, 8'h54, constant returned by register 7.
- RESET_RELOAD, 16'hFFFF, reload register value after reset.

Ports:
- clk  in  1  sys_clk, all logic on posedge.
- rst  in  1  Reset; synchronous, active-low. One clock; reset is synchronous and active-low. Top drives it with !sys_res.
- AD  in  3  register select.
- DI  in  8  write data from the CPU.
- DO  out  8  read data; combinational mux of AD.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  select, already qualified with vma.
- irq  out  1  interrupt request, active-high, level.
- tout  out  1  underflow toggle output (see Optional Feature).

Behaviour:
- Register map:
  - 0 CTRL: b0 EN, b1 IE, b2 AUTO (periodic reload); b7:3 read 0.
  - 1 STAT: b0 OVF; b7 RUN (mirror of EN). Writing 1 to b0 clears OVF.
  - 2 PRESC: 8-bit prescale value.
  - 3 CNT_H: reading returns cnt[15:8] and latches cnt[7:0] into lo_latch on that clock edge.
  - 4 CNT_L: returns lo_latch.
  - 5 RLD_H: write goes to rld_hi_buf; read returns rld[15:8].
  - 6 RLD_L: write commits rld <= {rld_hi_buf, DI} atomically; read returns rld[7:0].
  - 7 ID: reads ID_VALUE; writes ignored.
- Writes take effect on posedge clk when cs && !rw && rst.
- Read side effect (lo_latch capture) occurs when cs && rw.
- Reset (rst==0 at posedge):
  - CTRL=0, OVF=0, PRESC=0, cnt=0, lo_latch=0.
  - rld=RESET_RELOAD, rld_hi_buf=0, psc_cnt=0, tout=0.
  - irq=0.
- Prescaler:
  - psc_cnt is held at 0 while EN=0.
  - While EN=1, tick is asserted when psc_cnt==PRESC; psc_cnt then returns to 0, otherwise it increments.
  - PRESC=0 gives a tick every clock.
  - A PRESC write mid-run takes effect immediately. If psc_cnt > new PRESC, psc_cnt counts up, wraps through 255, and then matches.
- Start: a CTRL write taking EN 0->1 loads cnt<=rld and psc_cnt<=0. No tick occurs in that cycle.
- Counting, on each tick:
  - cnt!=0: cnt <= cnt-1.
  - cnt==0: set OVF; toggle tout. If AUTO=1, cnt <= rld. If AUTO=0, EN <= 0 and cnt stays 0 (one-shot).
- Period: (rld+1)*(PRESC+1) clocks from start to first OVF and between subsequent OVFs. rld=0 underflows every tick.
- RLD_L write while EN=0 also loads cnt <= new rld. While EN=1 the new value is used only at the next reload.
- irq = OVF & IE, combinational from registers. Clearing IE masks irq without clearing OVF.
- Simultaneous events:
  - OVF set (underflow) and W1C clear in the same cycle: set wins, OVF=1.
  - CTRL write clearing EN in the same cycle as underflow: EN=0 and cnt holds. OVF is still set and tout still toggles.
  - CTRL write with EN=1 while already running: no reload, counting continues.
- Reset mid-count restores all reset values on that edge, regardless of cs/rw.

Optional Feature:
- Macro: TIMERIO_TOUT_EN.
- Defined: tout toggles on every underflow as above, giving a square wave of period 2*(rld+1)*(PRESC+1) clocks in AUTO mode.
- Undefined: tout is tied to 0 and its flop is removed. All other behaviour is unchanged.

Decomposition:
- Shared package holds:
  - register offset constants (CTRL=0 ... ID=7);
  - CTRL bit indices EN/IE/AUTO;
  - STAT bit indices OVF/RUN;
  - the ID_VALUE default.
- One natural sub-module: timerio_prescaler (clk, rst, en, presc, tick), holding psc_cnt and tick generation.
- Register file, counter and bus mux stay in timerio.

Test Plan:
- Reset -> DO at AD=0 is 8'h00, AD=5/6 read 8'hFF/8'hFF, AD=7 reads 8'h54, irq=0, tout=0.
- Write RLD_H=8'h00, RLD_L=8'h03, PRESC=8'h01, CTRL=8'h07 -> OVF (and irq) asserts 8 clocks after the CTRL write, then every 8 clocks; tout toggles at each OVF.
- One-shot: rld=2, PRESC=0, CTRL=8'h01 -> OVF after 3 clocks, then STAT reads 8'h01 (RUN=0), cnt stays 0, irq stays 0 (IE=0).
- Atomic/latch: running with cnt=16'h1234 at the CNT_H read -> CNT_H returns 8'h12, and a later CNT_L returns 8'h34 even though cnt has since decremented.
- W1C race: write STAT=8'h01 on the exact cycle of an underflow -> OVF remains 1; a W1C in the next cycle clears it and irq drops.
- Reset asserted mid-count with EN=1, cnt=16'h0100 -> next edge gives CTRL=0, cnt=0, OVF=0, irq=0, and rld returns to 16'hFFFF.

Source files
------------

// File: rtl/timerio_pkg.sv
// Shared constants for the timerio interval timer: register offsets, bit indices, defaults.
package timerio_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CTRL_W = 3;

  localparam logic [ADDR_W-1:0] REG_CTRL  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_STAT  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PRESC = 3'd2;
  localparam logic [ADDR_W-1:0] REG_CNT_H = 3'd3;
  localparam logic [ADDR_W-1:0] REG_CNT_L = 3'd4;
  localparam logic [ADDR_W-1:0] REG_RLD_H = 3'd5;
  localparam logic [ADDR_W-1:0] REG_RLD_L = 3'd6;
  localparam logic [ADDR_W-1:0] REG_ID    = 3'd7;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_AUTO = 2;

  localparam int unsigned STAT_OVF = 0;
  localparam int unsigned STAT_RUN = 7;

  localparam logic [DATA_W-1:0] ID_VALUE_DEF     = 8'h54;
  localparam logic [CNT_W-1:0]  RESET_RELOAD_DEF = 16'hFFFF;

endpackage

// File: rtl/timerio_prescaler.sv
// Prescaler for timerio: counts 0..presc while enabled and pulses tick on the match.
module timerio_prescaler
  import timerio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] presc,
  output logic              tick
);

  logic [DATA_W-1:0] psc_cnt_q, psc_cnt_d;

  // A lowered presc below the current count wraps through 255 before matching.
  assign tick = en && (psc_cnt_q == presc);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (!en || tick) begin
      psc_cnt_d = '0;
    end else begin
      psc_cnt_d = psc_cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/timerio.sv
// 16-bit down-counting interval timer on the CPU bus with prescaler, reload and sticky overflow.
// Optional underflow toggle output on tout is built only when TIMERIO_TOUT_EN is defined.
module timerio
  import timerio_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE     = ID_VALUE_DEF,
  parameter logic [CNT_W-1:0]  RESET_RELOAD = RESET_RELOAD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AD,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              rw,
  input  logic              cs,
  output logic              irq,
  output logic              tout
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] lo_latch_q, lo_latch_d;
  logic [CNT_W-1:0]  rld_q, rld_d;
  logic [DATA_W-1:0] rld_hi_q, rld_hi_d;

  logic tick;
  logic wr, rd;
  logic ctrl_wr, stat_wr, presc_wr, rldh_wr, rldl_wr, cnth_rd;
  logic underflow, start, stop_wr;

  timerio_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_q[CTRL_EN]),
    .presc (presc_q),
    .tick  (tick)
  );

  assign wr       = cs && !rw;
  assign rd       = cs && rw;
  assign ctrl_wr  = wr && (AD == REG_CTRL);
  assign stat_wr  = wr && (AD == REG_STAT);
  assign presc_wr = wr && (AD == REG_PRESC);
  assign rldh_wr  = wr && (AD == REG_RLD_H);
  assign rldl_wr  = wr && (AD == REG_RLD_L);
  assign cnth_rd  = rd && (AD == REG_CNT_H);

  assign underflow = tick && (cnt_q == '0);
  assign start     = ctrl_wr && DI[CTRL_EN] && !ctrl_q[CTRL_EN];
  assign stop_wr   = ctrl_wr && !DI[CTRL_EN];

  // Next-state for the register file and counter.
  always_comb begin
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    lo_latch_d = lo_latch_q;
    rld_d      = rld_q;
    rld_hi_d   = rld_hi_q;

    if (ctrl_wr) begin
      ctrl_d = DI[CTRL_W-1:0];
    end
    if (underflow && !ctrl_q[CTRL_AUTO]) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end

    // Underflow set takes priority over a same-cycle write-1-to-clear.
    if (stat_wr && DI[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (underflow) begin
      ovf_d = 1'b1;
    end

    if (presc_wr) begin
      presc_d = DI;
    end
    if (rldh_wr) begin
      rld_hi_d = DI;
    end
    if (rldl_wr) begin
      rld_d = {rld_hi_q, DI};
    end
    if (cnth_rd) begin
      lo_latch_d = cnt_q[DATA_W-1:0];
    end

    if (start) begin
      cnt_d = rld_q;
    end else if (rldl_wr && !ctrl_q[CTRL_EN]) begin
      cnt_d = {rld_hi_q, DI};
    end else if (tick && !stop_wr) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (ctrl_q[CTRL_AUTO]) begin
        cnt_d = rld_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      cnt_q      <= '0;
      lo_latch_q <= '0;
      rld_q      <= RESET_RELOAD;
      rld_hi_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      lo_latch_q <= lo_latch_d;
      rld_q      <= rld_d;
      rld_hi_q   <= rld_hi_d;
    end
  end

`ifdef TIMERIO_TOUT_EN
  logic tout_q, tout_d;

  always_comb begin
    tout_d = tout_q;
    if (underflow) begin
      tout_d = !tout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tout_q <= 1'b0;
    end else begin
      tout_q <= tout_d;
    end
  end

  assign tout = tout_q;
`else
  assign tout = 1'b0;
`endif

  assign irq = ovf_q & ctrl_q[CTRL_IE];

  // Read mux, purely a function of AD and register state.
  always_comb begin
    DO = '0;
    case (AD)
      REG_CTRL:  DO = {(DATA_W - CTRL_W)'(0), ctrl_q};
      REG_STAT:  DO = {ctrl_q[CTRL_EN], 6'b000000, ovf_q};
      REG_PRESC: DO = presc_q;
      REG_CNT_H: DO = cnt_q[CNT_W-1:DATA_W];
      REG_CNT_L: DO = lo_latch_q;
      REG_RLD_H: DO = rld_q[CNT_W-1:DATA_W];
      REG_RLD_L: DO = rld_q[DATA_W-1:0];
      REG_ID:    DO = ID_VALUE;
      default:   DO = '0;
    endcase
  end

endmodule

// File: tb/tb_timerio.sv
// Directed self-checking bench for timerio: reset, periodic, one-shot, latch, W1C race, mid-count reset.
module tb_timerio;

  logic       clk;
  logic       rst;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;
  logic       tout;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef TIMERIO_TOUT_EN
  localparam logic TOUT_ON = 1'b1;
`else
  localparam logic TOUT_ON = 1'b0;
`endif

  timerio dut (
    .clk  (clk),
    .rst  (rst),
    .AD   (AD),
    .DI   (DI),
    .DO   (DO),
    .rw   (rw),
    .cs   (cs),
    .irq  (irq),
    .tout (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus write landing on the next rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  // Bus read with side effects on the next rising edge; data sampled before the edge.
  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1;
    d = DO;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  // Side-effect-free look at the read mux.
  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    AD = a;
    #1;
    d = DO;
  endtask

  logic [7:0] d;

  initial begin
    rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = '0; DI = '0;
    tick_n(3);

    // Reset values
    peek(3'd0, d); chk("rst_ctrl", 16'(d), 16'h00);
    peek(3'd5, d); chk("rst_rld_h", 16'(d), 16'hFF);
    peek(3'd6, d); chk("rst_rld_l", 16'(d), 16'hFF);
    peek(3'd7, d); chk("rst_id", 16'(d), 16'h54);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_tout", 16'(tout), 16'h0);
    rst = 1'b1;
    tick_n(1);

    bus_write(3'd7, 8'hAA);
    peek(3'd7, d); chk("id_ro", 16'(d), 16'h54);

    // Periodic: rld=3, PRESC=1 -> underflow every 8 clocks
    bus_write(3'd5, 8'h00);
    bus_write(3'd6, 8'h03);
    bus_write(3'd2, 8'h01);
    bus_write(3'd0, 8'h07);
    tick_n(7);
    chk("per_irq_e7", 16'(irq), 16'h0);
    chk("per_tout_e7", 16'(tout), 16'h0);
    tick_n(1);
    chk("per_irq_e8", 16'(irq), 16'h1);
    chk("per_tout_e8", 16'(tout), 16'(TOUT_ON));
    peek(3'd1, d); chk("per_stat_e8", 16'(d), 16'h81);
    bus_write(3'd1, 8'h01);
    chk("per_irq_clr", 16'(irq), 16'h0);
    tick_n(6);
    chk("per_irq_e15", 16'(irq), 16'h0);
    tick_n(1);
    chk("per_irq_e16", 16'(irq), 16'h1);
    chk("per_tout_e16", 16'(tout), 16'h0);

    // W1C landing on the underflow edge: set wins
    tick_n(7);
    bus_write(3'd1, 8'h01);
    peek(3'd1, d); chk("race_stat", 16'(d), 16'h81);
    chk("race_irq", 16'(irq), 16'h1);
    bus_write(3'd1, 8'h01);
    peek(3'd1, d); chk("race_clr_stat", 16'(d), 16'h80);
    chk("race_clr_irq", 16'(irq), 16'h0);
    bus_write(3'd0, 8'h00);

    // One-shot: rld=2, PRESC=0 -> OVF 3 clocks after start, then stop
    bus_write(3'd6, 8'h02);
    bus_write(3'd2, 8'h00);
    bus_write(3'd0, 8'h01);
    tick_n(2);
    peek(3'd1, d); chk("os_stat_e2", 16'(d), 16'h80);
    tick_n(1);
    peek(3'd1, d); chk("os_stat_e3", 16'(d), 16'h01);
    chk("os_irq", 16'(irq), 16'h0);
    tick_n(3);
    peek(3'd1, d); chk("os_stat_hold", 16'(d), 16'h01);
    peek(3'd3, d); chk("os_cnt_h", 16'(d), 16'h00);
    bus_write(3'd1, 8'h01);

    // Latched read: cnt=0x1234, PRESC=15 -> ticks 16 clocks apart
    bus_write(3'd5, 8'h12);
    bus_write(3'd6, 8'h34);
    bus_write(3'd2, 8'h0F);
    bus_write(3'd0, 8'h01);
    bus_read(3'd3, d); chk("lat_cnt_h", 16'(d), 16'h12);
    tick_n(40);
    peek(3'd4, d); chk("lat_cnt_l", 16'(d), 16'h34);
    bus_read(3'd3, d); chk("lat_cnt_h2", 16'(d), 16'h12);
    peek(3'd4, d); chk("lat_cnt_l2", 16'(d), 16'h32);
    bus_write(3'd0, 8'h00);

    // Mid-count reset with cnt=0x0100, running, bus write present
    bus_write(3'd5, 8'h01);
    bus_write(3'd6, 8'h00);
    bus_write(3'd2, 8'hFF);
    bus_write(3'd0, 8'h03);
    peek(3'd3, d); chk("mid_cnt_h", 16'(d), 16'h01);
    rst = 1'b0; cs = 1'b1; rw = 1'b0; AD = 3'd0; DI = 8'h07;
    tick_n(1);
    cs = 1'b0; rw = 1'b1;
    peek(3'd0, d); chk("mrst_ctrl", 16'(d), 16'h00);
    peek(3'd3, d); chk("mrst_cnt_h", 16'(d), 16'h00);
    peek(3'd1, d); chk("mrst_stat", 16'(d), 16'h00);
    peek(3'd5, d); chk("mrst_rld_h", 16'(d), 16'hFF);
    peek(3'd6, d); chk("mrst_rld_l", 16'(d), 16'hFF);
    chk("mrst_irq", 16'(irq), 16'h0);
    chk("mrst_tout", 16'(tout), 16'h0);
    rst = 1'b1;
    tick_n(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
